// File: rtl/rank_insert_arb_pkg.sv
// Shared constants, rank op codes and config reset defaults for the rank pipe insert path.
package rank_pipe_pkg;
  localparam int NUM_PORTS         = 4;
  localparam int L2_NUM_PORTS      = 2;
  localparam int META_WIDTH        = 16;
  localparam int FLOW_ID_WIDTH     = 16;
  localparam int FLOW_WEIGHT_WIDTH = 8;
  localparam int RANK_CODE_BITS    = 2;
  localparam int NUM_RANK_OPS      = 3;
  localparam int CNT_WIDTH         = 32;

  typedef enum logic [RANK_CODE_BITS-1:0] {
    STRICT_OP = 2'd0,
    RR_OP     = 2'd1,
    WRR_OP    = 2'd2
  } rank_op_e;

  localparam logic [RANK_CODE_BITS-1:0]    CFG_RANK_OP_RST = STRICT_OP;
  localparam logic [FLOW_WEIGHT_WIDTH-1:0] CFG_WEIGHT_RST  = 8'd1;

  // Unknown op codes fall back to strict priority rather than reaching the pipe.
  function automatic logic [RANK_CODE_BITS-1:0] legal_rank_op(input logic [RANK_CODE_BITS-1:0] op);
    return (int'(op) < NUM_RANK_OPS) ? op : CFG_RANK_OP_RST;
  endfunction
endpackage

// File: rtl/rank_insert_arb_if.sv
// Request-side and rank-pipe-side signals of the insert arbiter.
// Requests: a request transfers on a clock edge where req_valid[p] and req_ready[p] are both
// high; the requester holds valid and data stable until then. Pipe: no ready, pipe_insert is
// raised only while pipe_busy is low.
interface rank_insert_arb_if #(
  parameter int NUM_PORTS         = rank_pipe_pkg::NUM_PORTS,
  parameter int META_WIDTH        = rank_pipe_pkg::META_WIDTH,
  parameter int FLOW_ID_WIDTH     = rank_pipe_pkg::FLOW_ID_WIDTH,
  parameter int FLOW_WEIGHT_WIDTH = rank_pipe_pkg::FLOW_WEIGHT_WIDTH,
  parameter int RANK_CODE_BITS    = rank_pipe_pkg::RANK_CODE_BITS
);
  logic [NUM_PORTS-1:0]               req_valid;
  logic [NUM_PORTS-1:0]               req_ready;
  logic [NUM_PORTS*META_WIDTH-1:0]    req_meta;
  logic [NUM_PORTS*FLOW_ID_WIDTH-1:0] req_flowID;
  logic                               pipe_busy;
  logic                               pipe_insert;
  logic [META_WIDTH-1:0]              pipe_meta;
  logic [FLOW_ID_WIDTH-1:0]           pipe_flowID;
  logic [RANK_CODE_BITS-1:0]          pipe_rank_op;
  logic [FLOW_WEIGHT_WIDTH-1:0]       pipe_flow_weight;

  modport master (
    input  req_valid, req_meta, req_flowID, pipe_busy,
    output req_ready, pipe_insert, pipe_meta, pipe_flowID, pipe_rank_op, pipe_flow_weight
  );

  modport slave (
    output req_valid, req_meta, req_flowID, pipe_busy,
    input  req_ready, pipe_insert, pipe_meta, pipe_flowID, pipe_rank_op, pipe_flow_weight
  );
endinterface

// File: rtl/rank_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, modulo NUM_PORTS.
module rank_rr_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int L2_NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]    req_i,
  input  logic [L2_NUM_PORTS-1:0] rr_ptr_i,
  input  logic                    enable_i,
  output logic [NUM_PORTS-1:0]    grant_o,
  output logic [L2_NUM_PORTS-1:0] grant_idx_o
);
  logic [L2_NUM_PORTS-1:0] cand;
  logic                    found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      // Power-of-two port count lets the index wrap for free.
      cand = rr_ptr_i + L2_NUM_PORTS'(i);
      if (enable_i && !found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end
endmodule

// File: rtl/rank_insert_arb.sv
// Round-robin sharing of the rank pipe insert port between NUM_PORTS requesters, tagging each
// grant with the port's configured rank op and weight and counting grants per port.
module rank_insert_arb #(
  parameter int NUM_PORTS         = rank_pipe_pkg::NUM_PORTS,
  parameter int L2_NUM_PORTS      = rank_pipe_pkg::L2_NUM_PORTS,
  parameter int META_WIDTH        = rank_pipe_pkg::META_WIDTH,
  parameter int FLOW_ID_WIDTH     = rank_pipe_pkg::FLOW_ID_WIDTH,
  parameter int FLOW_WEIGHT_WIDTH = rank_pipe_pkg::FLOW_WEIGHT_WIDTH,
  parameter int RANK_CODE_BITS    = rank_pipe_pkg::RANK_CODE_BITS,
  parameter int NUM_RANK_OPS      = rank_pipe_pkg::NUM_RANK_OPS,
  parameter int CNT_WIDTH         = rank_pipe_pkg::CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  rank_insert_arb_if.master            bus,
  input  logic                         cfg_wr_en,
  input  logic [L2_NUM_PORTS-1:0]      cfg_wr_port,
  input  logic [RANK_CODE_BITS-1:0]    cfg_rank_op,
  input  logic [FLOW_WEIGHT_WIDTH-1:0] cfg_weight,
  input  logic                         cfg_clr_cnt,
  input  logic [L2_NUM_PORTS-1:0]      cfg_rd_port,
  output logic [CNT_WIDTH-1:0]         cfg_rd_cnt
);
  import rank_pipe_pkg::*;

  logic [NUM_PORTS-1:0]         hold_valid_q, hold_valid_d;
  logic [META_WIDTH-1:0]        hold_meta_q [NUM_PORTS];
  logic [FLOW_ID_WIDTH-1:0]     hold_flow_q [NUM_PORTS];
  logic [RANK_CODE_BITS-1:0]    cfg_op_q    [NUM_PORTS];
  logic [FLOW_WEIGHT_WIDTH-1:0] cfg_wt_q    [NUM_PORTS];
  logic [CNT_WIDTH-1:0]         cnt_q       [NUM_PORTS];
  logic [CNT_WIDTH-1:0]         cnt_d       [NUM_PORTS];
  logic [L2_NUM_PORTS-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]         grant, ready, accept;
  logic [L2_NUM_PORTS-1:0]      grant_idx;
  logic                         any_grant;

  rank_rr_arbiter #(
    .NUM_PORTS   (NUM_PORTS),
    .L2_NUM_PORTS(L2_NUM_PORTS)
  ) u_arb (
    .req_i      (hold_valid_q),
    .rr_ptr_i   (rr_ptr_q),
    .enable_i   (~rst & ~bus.pipe_busy),
    .grant_o    (grant),
    .grant_idx_o(grant_idx)
  );

  assign any_grant     = |grant;
  // A port being granted this cycle can take a new request on the same edge.
  assign ready         = {NUM_PORTS{~rst}} & (~hold_valid_q | grant);
  assign accept        = bus.req_valid & ready;
  assign bus.req_ready = ready;

  always_comb begin
    hold_valid_d = (hold_valid_q & ~grant) | accept;
    rr_ptr_d     = any_grant ? grant_idx + L2_NUM_PORTS'(1) : rr_ptr_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cnt_d[p] = cnt_q[p];
      if (cfg_clr_cnt) begin
        cnt_d[p] = '0;
      end else if (grant[p] && !(&cnt_q[p])) begin
        cnt_d[p] = cnt_q[p] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        cfg_op_q[p] <= RANK_CODE_BITS'(CFG_RANK_OP_RST);
        cfg_wt_q[p] <= FLOW_WEIGHT_WIDTH'(CFG_WEIGHT_RST);
        cnt_q[p]    <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        cnt_q[p] <= cnt_d[p];
      end
      // Grants this cycle already read the old entry through the output mux.
      if (cfg_wr_en) begin
        cfg_op_q[cfg_wr_port] <= RANK_CODE_BITS'(legal_rank_op(cfg_rank_op));
        cfg_wt_q[cfg_wr_port] <= cfg_weight;
      end
    end
  end

  // Payload needs no reset: it is only visible behind a valid grant.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (accept[p]) begin
        hold_meta_q[p] <= bus.req_meta[p*META_WIDTH +: META_WIDTH];
        hold_flow_q[p] <= bus.req_flowID[p*FLOW_ID_WIDTH +: FLOW_ID_WIDTH];
      end
    end
  end

  assign bus.pipe_insert      = any_grant;
  assign bus.pipe_meta        = any_grant ? hold_meta_q[grant_idx] : '0;
  assign bus.pipe_flowID      = any_grant ? hold_flow_q[grant_idx] : '0;
  assign bus.pipe_rank_op     = any_grant ? cfg_op_q[grant_idx]    : '0;
  assign bus.pipe_flow_weight = any_grant ? cfg_wt_q[grant_idx]    : '0;
  assign cfg_rd_cnt           = rst ? '0 : cnt_q[cfg_rd_port];
endmodule

// File: tb/tb_rank_insert_arb.sv
// Bench for rank_insert_arb: per-port request queues, a transaction-level reference model
// feeding an expected queue, and an insert monitor draining it.
module tb_rank_insert_arb;
  import rank_pipe_pkg::*;

  localparam int N  = NUM_PORTS;
  localparam int MW = META_WIDTH;
  localparam int FW = FLOW_ID_WIDTH;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int EW = 60;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_wr_en;
  logic [1:0]    cfg_wr_port;
  logic [1:0]    cfg_rank_op;
  logic [7:0]    cfg_weight;
  logic          cfg_clr_cnt;
  logic [1:0]    cfg_rd_port;
  logic [CW-1:0] cfg_rd_cnt;

  rank_insert_arb_if bus();

  rank_insert_arb #(.CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.master),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_wr_port(cfg_wr_port),
    .cfg_rank_op(cfg_rank_op),
    .cfg_weight (cfg_weight),
    .cfg_clr_cnt(cfg_clr_cnt),
    .cfg_rd_port(cfg_rd_port),
    .cfg_rd_cnt (cfg_rd_cnt)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q [$];
  logic [31:0]   port_q [N][$];
  logic [N-1:0]  m_hv;
  logic [15:0]   m_meta [N];
  logic [15:0]   m_flow [N];
  logic [1:0]    m_op   [N];
  logic [7:0]    m_wt   [N];
  int            m_cnt  [N];
  int            m_ptr;
  logic [N-1:0]  acc_r = '0;

  task automatic model_reset();
    m_hv  = '0;
    m_ptr = 0;
    for (int q = 0; q < N; q++) begin
      m_op[q]  = 2'd0;
      m_wt[q]  = 8'd1;
      m_cnt[q] = 0;
    end
  endtask

  initial model_reset();

  always @(negedge clk) begin
    int g;
    int p;
    logic [N-1:0] rdy;
    g = -1;
    if (!rst && !bus.pipe_busy) begin
      for (int k = 0; k < N; k++) begin
        p = (m_ptr + k) % N;
        if (g < 0 && m_hv[p]) g = p;
      end
    end
    for (int q = 0; q < N; q++) rdy[q] = !rst && (!m_hv[q] || g == q);
    chk("req_ready", 64'(bus.req_ready), 64'(rdy));
    chk("cfg_rd_cnt", 64'(cfg_rd_cnt), rst ? 64'd0 : 64'(m_cnt[cfg_rd_port]));
    if (g >= 0) exp_q.push_back({cyc, 2'(g), m_meta[g], m_flow[g], m_op[g], m_wt[g]});
    acc_r = bus.req_valid & rdy;
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_hv[g] = 1'b0;
        m_ptr   = (g + 1) % N;
        if (m_cnt[g] != CNT_MAX) m_cnt[g]++;
      end
      for (int q = 0; q < N; q++) begin
        if (acc_r[q]) begin
          m_hv[q]   = 1'b1;
          m_meta[q] = bus.req_meta[q*MW +: MW];
          m_flow[q] = bus.req_flowID[q*FW +: FW];
        end
      end
      if (cfg_clr_cnt) for (int q = 0; q < N; q++) m_cnt[q] = 0;
      if (cfg_wr_en) begin
        m_op[cfg_wr_port] = (int'(cfg_rank_op) >= NUM_RANK_OPS) ? 2'd0 : cfg_rank_op;
        m_wt[cfg_wr_port] = cfg_weight;
      end
    end
  end

  // ---------------- request driver ----------------
  always @(posedge clk) begin
    logic [31:0] item;
    #1;
    for (int p = 0; p < N; p++) begin
      if (!bus.req_valid[p] || acc_r[p]) begin
        if (port_q[p].size() > 0) begin
          item = port_q[p].pop_front();
          bus.req_valid[p]            = 1'b1;
          bus.req_meta[p*MW +: MW]    = item[31:16];
          bus.req_flowID[p*FW +: FW]  = item[15:0];
        end else begin
          bus.req_valid[p] = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [25:0] ins_log [$];
  logic [15:0] last_meta = '0;
  logic [1:0]  last_op   = 2'd3;
  logic [7:0]  last_wt   = '0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic hit;
    #1;
    hit = (exp_q.size() > 0) && (exp_q[0][59:44] == cyc);
    chk("pipe_insert", 64'(bus.pipe_insert), 64'(hit));
    if (hit) begin
      e = exp_q.pop_front();
      chk("pipe_data", 64'({bus.pipe_meta, bus.pipe_flowID, bus.pipe_rank_op, bus.pipe_flow_weight}),
          64'(e[41:0]));
    end else begin
      chk("pipe_idle_data", 64'({bus.pipe_meta, bus.pipe_flowID, bus.pipe_rank_op, bus.pipe_flow_weight}),
          64'd0);
    end
    if (bus.pipe_insert) begin
      last_meta = bus.pipe_meta;
      last_op   = bus.pipe_rank_op;
      last_wt   = bus.pipe_flow_weight;
      ins_log.push_back({bus.pipe_meta, bus.pipe_rank_op, bus.pipe_flow_weight});
    end
  end

  // ---------------- helpers ----------------
  function automatic bit idle();
    bit r = (bus.req_valid == '0) && (m_hv == '0);
    for (int p = 0; p < N; p++) if (port_q[p].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input string name);
    int t = 0;
    while (t < 300 && !idle()) begin
      tick();
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, t);
    end
    tick(2);
  endtask

  task automatic check_cnt(input int p, input int exp, input string name);
    cfg_rd_port = 2'(p);
    @(negedge clk);
    #2;
    chk(name, 64'(cfg_rd_cnt), 64'(exp));
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_port = '0; cfg_rank_op = '0; cfg_weight = '0;
    cfg_clr_cnt = 1'b0; cfg_rd_port = '0;
    bus.pipe_busy = 1'b0; bus.req_valid = '0; bus.req_meta = '0; bus.req_flowID = '0;
    tick(3);
    rst = 1'b0;

    // single request on port 2 with default config
    port_q[2].push_back({16'h1234, 16'h0007});
    wait_idle("t1_idle");
    chk("t1_meta", 64'(last_meta), 64'h1234);
    chk("t1_op", 64'(last_op), 64'd0);
    chk("t1_wt", 64'(last_wt), 64'd1);
    check_cnt(2, 1, "t1_cnt2");

    // all ports continuously valid
    pulse_rst();
    ins_log.delete();
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < N; p++) port_q[p].push_back({8'(p), 8'(i), 16'(p * 16 + i)});
    wait_idle("t2_idle");
    chk("t2_count", 64'(ins_log.size()), 64'd12);
    for (int k = 0; k < ins_log.size(); k++) chk("t2_order", 64'(ins_log[k][25:18]), 64'(k % N));
    for (int p = 0; p < N; p++) check_cnt(p, 3, "t2_cnt");

    // busy holds ports 1 and 3
    bus.pipe_busy = 1'b1;
    port_q[1].push_back({16'h0100, 16'h0011});
    port_q[3].push_back({16'h0300, 16'h0033});
    tick(3);
    @(negedge clk); #2;
    chk("t3_ready1", 64'(bus.req_ready[1]), 64'd0);
    chk("t3_ready3", 64'(bus.req_ready[3]), 64'd0);
    chk("t3_insert", 64'(bus.pipe_insert), 64'd0);
    tick(2);
    ins_log.delete();
    bus.pipe_busy = 1'b0;
    wait_idle("t3_idle");
    chk("t3_count", 64'(ins_log.size()), 64'd2);
    if (ins_log.size() == 2) begin
      chk("t3_first", 64'(ins_log[0][25:10]), 64'h0100);
      chk("t3_second", 64'(ins_log[1][25:10]), 64'h0300);
    end

    // config write in the same cycle as a port 1 grant
    bus.pipe_busy = 1'b1;
    port_q[1].push_back({16'h0401, 16'h0041});
    tick(3);
    bus.pipe_busy = 1'b0;
    cfg_wr_en = 1'b1; cfg_wr_port = 2'd1; cfg_rank_op = 2'd2; cfg_weight = 8'd5;
    tick();
    cfg_wr_en = 1'b0;
    chk("t4_old_op", 64'(last_op), 64'd0);
    chk("t4_old_wt", 64'(last_wt), 64'd1);
    port_q[1].push_back({16'h0402, 16'h0042});
    wait_idle("t4_idle_a");
    chk("t4_new_op", 64'(last_op), 64'd2);
    chk("t4_new_wt", 64'(last_wt), 64'd5);
    cfg_wr_en = 1'b1; cfg_wr_port = 2'd1; cfg_rank_op = 2'd3; cfg_weight = 8'd9;
    tick();
    cfg_wr_en = 1'b0;
    port_q[1].push_back({16'h0403, 16'h0043});
    wait_idle("t4_idle_b");
    chk("t4_bad_op", 64'(last_op), 64'd0);
    chk("t4_bad_wt", 64'(last_wt), 64'd9);

    // counter saturation, then clear against a grant
    cfg_clr_cnt = 1'b1;
    tick();
    cfg_clr_cnt = 1'b0;
    for (int i = 0; i < 17; i++) port_q[0].push_back({16'h0500 + 16'(i), 16'h0050});
    wait_idle("t5_idle");
    check_cnt(0, 15, "t5_sat");
    bus.pipe_busy = 1'b1;
    port_q[0].push_back({16'h0511, 16'h0051});
    tick(3);
    bus.pipe_busy = 1'b0;
    cfg_clr_cnt = 1'b1;
    tick();
    cfg_clr_cnt = 1'b0;
    check_cnt(0, 0, "t5_clr_wins");

    // reset while three ports hold requests
    cfg_wr_en = 1'b1; cfg_wr_port = 2'd2; cfg_rank_op = 2'd1; cfg_weight = 8'd7;
    tick();
    cfg_wr_en = 1'b0;
    bus.pipe_busy = 1'b1;
    port_q[0].push_back({16'h0600, 16'h0060});
    port_q[2].push_back({16'h0602, 16'h0062});
    port_q[3].push_back({16'h0603, 16'h0063});
    tick(3);
    pulse_rst();
    bus.pipe_busy = 1'b0;
    @(negedge clk); #2;
    chk("t6_no_insert", 64'(bus.pipe_insert), 64'd0);
    tick();
    ins_log.delete();
    port_q[0].push_back({16'h0610, 16'h0070});
    port_q[2].push_back({16'h0612, 16'h0072});
    port_q[3].push_back({16'h0613, 16'h0073});
    wait_idle("t6_idle");
    chk("t6_count", 64'(ins_log.size()), 64'd3);
    if (ins_log.size() == 3) begin
      chk("t6_first", 64'(ins_log[0][25:10]), 64'h0610);
      chk("t6_port2_cfg", 64'(ins_log[1]), 64'({16'h0612, 2'd0, 8'd1}));
      chk("t6_third", 64'(ins_log[2][25:10]), 64'h0613);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.pipe_busy = ($urandom_range(0, 99) < 30);
      for (int p = 0; p < N; p++)
        if (port_q[p].size() < 2 && $urandom_range(0, 1) == 1)
          port_q[p].push_back($urandom);
      cfg_wr_en   = ($urandom_range(0, 9) == 0);
      cfg_wr_port = 2'($urandom_range(0, 3));
      cfg_rank_op = 2'($urandom_range(0, 3));
      cfg_weight  = 8'($urandom_range(0, 255));
      cfg_clr_cnt = ($urandom_range(0, 49) == 0);
      cfg_rd_port = 2'($urandom_range(0, 3));
      rst         = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; bus.pipe_busy = 1'b0; cfg_wr_en = 1'b0; cfg_clr_cnt = 1'b0;
    wait_idle("rand_idle");
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
